// File: rtl/mem_bus_sequencer.sv
// Multicycle SysBus strobe sequencer: turns one read/write request into the
// ALE / nME / nOE / nWE / ENB beat sequence, with wait states, ready stretching and bursts.
module mem_bus_sequencer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 1,
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                               Clock,
  input  logic                               Reset,
  input  logic                               Req,
  input  logic                               Write,
  input  logic [ADDR_W-1:0]                  Addr,
  input  logic [$clog2(MAX_BURST+1)-1:0]     Len,
  input  logic [DATA_W-1:0]                  WData,
  output logic                               WDataAck,
  output logic [DATA_W-1:0]                  RData,
  output logic                               RValid,
  output logic                               Busy,
  output logic                               Done,
  output logic                               Err,
  output logic [DATA_W-1:0]                  SysBusOut,
  input  logic [DATA_W-1:0]                  SysBusIn,
  output logic                               MemEn,
  output logic                               ALE,
  output logic                               nME,
  output logic                               nOE,
  output logic                               nWE,
  output logic                               ENB,
  input  logic                               MemRdy
);

  localparam int LEN_W = $clog2(MAX_BURST + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);
  localparam logic [4:0]       WS      = 5'(WAIT_STATES);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, DATA, RECOV} stateT;

  stateT             state;
  logic              isWrite;
  logic [ADDR_W-1:0] curAddr;
  logic [LEN_W-1:0]  beatsLeft;
  logic [4:0]        waitCnt;
  logic [TO_W-1:0]   toCnt;

  logic [LEN_W-1:0]  effLen;
  logic [ADDR_W-1:0] nextAddr;
  logic              minDone;
  logic              postMin;
  logic              toExpire;

  // waitCnt saturates at WS, so it equals WS exactly on the stretch cycles
  assign effLen   = (Len == '0) ? ONE_LEN : ((Len > MAX_LEN) ? MAX_LEN : Len);
  assign nextAddr = curAddr + ADDR_W'(1);
  assign minDone  = (WS == 5'd0) || (waitCnt >= (WS - 5'd1));
  assign postMin  = (waitCnt == WS);
  assign toExpire = (toCnt == TO_LAST);

  // Strobes are registered together with the state they belong to; they hold
  // their value unless a transition changes them.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      isWrite   <= 1'b0;
      curAddr   <= '0;
      beatsLeft <= '0;
      waitCnt   <= '0;
      toCnt     <= '0;
      ALE       <= 1'b0;
      ENB       <= 1'b0;
      MemEn     <= 1'b0;
      nME       <= 1'b1;
      nOE       <= 1'b1;
      nWE       <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      RValid    <= 1'b0;
      WDataAck  <= 1'b0;
      RData     <= '0;
      SysBusOut <= '0;
    end else begin
      ALE      <= 1'b0;
      ENB      <= 1'b0;
      Done     <= 1'b0;
      Err      <= 1'b0;
      RValid   <= 1'b0;
      WDataAck <= 1'b0;
      case (state)
        IDLE: begin
          if (Req) begin
            isWrite   <= Write;
            curAddr   <= Addr;
            beatsLeft <= effLen;
            Busy      <= 1'b1;
            ALE       <= 1'b1;
            nME       <= 1'b0;
            MemEn     <= 1'b1;
            SysBusOut <= DATA_W'(Addr);
            state     <= ADDR;
          end
        end
        ADDR: begin
          waitCnt <= '0;
          toCnt   <= '0;
          nME     <= 1'b0;
          if (isWrite) begin
            nWE       <= 1'b0;
            MemEn     <= 1'b1;
            SysBusOut <= WData;
          end else begin
            nOE   <= 1'b0;
            MemEn <= 1'b0;
          end
          // With no mandatory wait states a ready memory skips WAIT entirely
          if ((WS == 5'd0) && MemRdy) begin
            WDataAck <= isWrite;
            ENB      <= !isWrite;
            state    <= DATA;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (isWrite) SysBusOut <= WData;
          if (minDone && MemRdy) begin
            WDataAck <= isWrite;
            ENB      <= !isWrite;
            state    <= DATA;
          end else if (postMin && toExpire) begin
            nME   <= 1'b1;
            nOE   <= 1'b1;
            nWE   <= 1'b1;
            MemEn <= 1'b0;
            Done  <= 1'b1;
            Err   <= 1'b1;
            state <= RECOV;
          end else begin
            if (!postMin) waitCnt <= waitCnt + 5'd1;
            if (postMin) toCnt <= toCnt + TO_W'(1);
          end
        end
        DATA: begin
          if (!isWrite) begin
            RData  <= SysBusIn;
            RValid <= 1'b1;
          end
          beatsLeft <= beatsLeft - ONE_LEN;
          if (beatsLeft > ONE_LEN) begin
            curAddr   <= nextAddr;
            ALE       <= 1'b1;
            nME       <= 1'b0;
            nOE       <= 1'b1;
            nWE       <= 1'b1;
            MemEn     <= 1'b1;
            SysBusOut <= DATA_W'(nextAddr);
            state     <= ADDR;
          end else begin
            nME   <= 1'b1;
            nOE   <= 1'b1;
            nWE   <= 1'b1;
            MemEn <= 1'b0;
            Done  <= 1'b1;
            state <= RECOV;
          end
        end
        RECOV: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_sequencer.md
# mem_bus_sequencer

Parametrised multicycle memory-bus sequencer that generates the external SysBus strobe sequence (ALE, nME, nOE, nWE, ENB, MemEn) for single and burst read/write transactions. It sits between the processor control FSM and the memory pads. The control FSM issues one request and waits for Done, instead of stepping through fixed sub-states itself. Compared with hard-coded fetch/execute bus phases, it adds:
- configurable wait states;
- memory-ready stretching with a timeout;
- multi-beat bursts with address auto-increment.

## Interface
Parameters:
- DATA_W, 16, SysBus and data width
- ADDR_W, 16, address width (ADDR_W ≤ DATA_W; address is driven on SysBus zero-extended)
- WAIT_STATES, 1, minimum wait cycles per beat (0..15)
- MAX_BURST, 4, maximum beats per request (≥1)
- TIMEOUT, 15, extra wait cycles allowed with MemRdy low before abort (≥1)

Ports:
- Clock  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  1  transaction request, sampled only in IDLE
- Write  in  1  1 = write, 0 = read; captured with Req
- Addr  in  ADDR_W  start address; captured with Req
- Len  in  $clog2(MAX_BURST+1)  beat count; 0 is treated as 1, values above MAX_BURST are clamped to MAX_BURST
- WData  in  DATA_W  write data for the current beat
- WDataAck  out  1  pulse: current beat's WData consumed, present the next beat's data
- RData  out  DATA_W  last read beat, registered
- RValid  out  1  one-cycle pulse: RData updated
- Busy  out  1  transaction in progress
- Done  out  1  one-cycle pulse: transaction finished
- Err  out  1  one-cycle pulse, coincident with Done: transaction aborted by timeout
- SysBusOut  out  DATA_W  address or write data driven to the pads
- SysBusIn  in  DATA_W  data from the pads
- MemEn  out  1  pad output enable (1 = block drives SysBus)
- ALE  out  1  address latch enable, active-high
- nME  out  1  memory enable, active-low
- nOE  out  1  output enable, active-low
- nWE  out  1  write enable, active-low
- ENB  out  1  read-data sample strobe, active-high
- MemRdy  in  1  memory ready; low stretches the wait phase

## Operation
- States: IDLE, ADDR, WAIT, DATA, RECOV.
- IDLE: Req=1 captures Write, Addr, the effective Len (beats remaining) and clears the beat address offset. Next state is ADDR. Busy=1 from the following cycle until the cycle IDLE is re-entered.
- ADDR, 1 cycle:
  - ALE=1, nME=0, MemEn=1.
  - SysBusOut = Addr + beat index, modulo 2^ADDR_W.
  - Next state is WAIT.
- WAIT:
  - nME=0. A read drives nOE=0 and MemEn=0. A write drives nWE=0, MemEn=1 and SysBusOut=WData.
  - The first WAIT_STATES cycles are unconditional.
  - After that, leave for DATA on the first cycle with MemRdy=1.
  - With WAIT_STATES=0, WAIT lasts 0 cycles when MemRdy=1 at the end of ADDR; otherwise it is entered and stretched.
- Timeout: a counter increments on each post-minimum WAIT cycle with MemRdy=0. When it reaches TIMEOUT, go to RECOV with the error flag set and drop the remaining beats.
- DATA, 1 cycle, same strobes as WAIT:
  - Read: ENB=1; RData is loaded from SysBusIn at the end of the cycle; RValid=1 on the next cycle.
  - Write: WDataAck=1.
  - Decrement beats remaining. If beats remain, go to ADDR with the next address; otherwise go to RECOV.
- RECOV, 1 cycle: all strobes inactive, MemEn=0, Done=1, and Err=1 if aborted. Next state is IDLE.
- Req is ignored outside IDLE. Minimum gap between requests is RECOV plus IDLE (2 cycles from Done to the next ALE).

## Timing
- Reset values, applied on the first rising edge with Reset=1 from any state:
  - state IDLE;
  - ALE=0, ENB=0, MemEn=0, nME=1, nOE=1, nWE=1;
  - Busy=0, Done=0, Err=0, RValid=0, WDataAck=0;
  - RData=0, SysBusOut=0;
  - counters 0.
- Reset mid-transaction aborts it with no Done and no Err.
- All outputs are registered or decoded from state only; no combinational path from Req to any output.
- Beat length with MemRdy=1 is 2+WAIT_STATES cycles.
- Transaction latency, Req accepted to Done, is 1 + Len·(2+WAIT_STATES) cycles (Done in RECOV).
- Beat-to-beat turnaround inside a burst has no idle cycle: DATA is followed directly by ADDR.
- WData must be stable from WAIT entry through DATA of its beat.

## Test plan
- Single read, WAIT_STATES=1, MemRdy=1, Addr=0x0040, SysBusIn=0xBEEF:
  - ALE cycle 1, WAIT cycle 2, ENB cycle 3;
  - RValid with RData=0xBEEF in cycle 4, coinciding with Done.
- Write burst, Len=3, Addr=0xFFFE:
  - ADDR phases drive 0xFFFE, 0xFFFF, 0x0000 (wrap);
  - three WDataAck pulses, nWE low each beat, one Done, Err=0.
- Read with MemRdy held low 5 cycles after minimum wait: WAIT stretches 5 cycles, then completes normally, Err=0.
- MemRdy stuck low, TIMEOUT=15: abort after 15 extra cycles; Done=1 and Err=1 in the same cycle; remaining beats not issued.
- Len=0 gives one beat; Len=7 with MAX_BURST=4 gives exactly 4 beats. Req pulsed while Busy is ignored.
- Reset asserted during WAIT of a write: next cycle all outputs are at reset values, no Done; a new Req afterwards completes normally.
